// File: rtl/video_test_pattern_gen.sv
// RGB test pattern generator (bars/gradient/checker, moving box with TEST_PATTERN_MOVING_BOX_EN); fixed 2-cycle latency.
// No backpressure: one pixel in and one pixel out every clock; pattern changes land only at frame start.
module video_test_pattern_gen #(
  parameter int H_ACTIVE           = 1280,
  parameter int V_ACTIVE           = 720,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int BOX_SIZE           = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dataEnable,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [11:0] hPos,
  input  logic [10:0] vPos,
  input  logic        autoAdvance,
  input  logic        advance,
  output logic        dataEnableOut,
  output logic        hSyncOut,
  output logic        vSyncOut,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic [1:0]  patternIndex
);

  localparam int FCW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_PATTERN - 1);
`ifdef TEST_PATTERN_MOVING_BOX_EN
  localparam logic [1:0] PAT_LAST = 2'd3;
`else
  localparam logic [1:0] PAT_LAST = 2'd2;
`endif

  if (FRAMES_PER_PATTERN < 1 || BOX_SIZE < 1 || BOX_SIZE > H_ACTIVE || BOX_SIZE > V_ACTIVE) begin : g_bad_cfg
    $error("video_test_pattern_gen: invalid parameters");
  end

  logic           fs;
  logic           fc_last;
  logic           adv_now;
  logic [FCW-1:0] fcnt;
  logic           pend;
  logic [1:0]     pat;
  logic [2:0]     bar_d;

  logic           de1, hs1, vs1, chk1;
  logic [7:0]     grad1;
  logic [2:0]     bar1;
  logic [23:0]    rgb_d;

  assign fs      = dataEnable && (hPos == 12'd0) && (vPos == 11'd0);
  assign fc_last = (fcnt == FC_LAST);
  assign adv_now = fs && ((fc_last && autoAdvance) || pend);
  assign patternIndex = pat;

  // Bar boundaries are elaboration-time constants k*H_ACTIVE/8.
  always_comb begin
    bar_d = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (hPos >= 12'(k * H_ACTIVE / 8)) bar_d = 3'(k);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fcnt <= '0;
      pend <= 1'b0;
      pat  <= 2'd0;
    end else if (fs) begin
      // A pulse coinciding with frame start waits for the next one.
      pend <= advance;
      fcnt <= (fc_last || pend) ? '0 : fcnt + FCW'(1);
      if (adv_now) pat <= (pat == PAT_LAST) ? 2'd0 : pat + 2'd1;
    end else if (advance) begin
      pend <= 1'b1;
    end
  end

`ifdef TEST_PATTERN_MOVING_BOX_EN
  localparam logic [11:0] X_MAX = 12'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - BOX_SIZE);

  logic [11:0] box_x, nx;
  logic [10:0] box_y, ny;
  logic        dir_x, dir_y, in_box, box1;

  assign nx = dir_x ? box_x + 12'd1 : box_x - 12'd1;
  assign ny = dir_y ? box_y + 11'd1 : box_y - 11'd1;
  // Frame-start pixel is tested against the pre-move position.
  assign in_box = ({1'b0, hPos} >= {1'b0, box_x}) &&
                  ({1'b0, hPos} <  {1'b0, box_x} + 13'(BOX_SIZE)) &&
                  ({1'b0, vPos} >= {1'b0, box_y}) &&
                  ({1'b0, vPos} <  {1'b0, box_y} + 12'(BOX_SIZE));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      box_x <= '0;
      box_y <= '0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
    end else if (fs) begin
      box_x <= nx;
      box_y <= ny;
      if (nx == 12'd0 || nx == X_MAX) dir_x <= ~dir_x;
      if (ny == 11'd0 || ny == Y_MAX) dir_y <= ~dir_y;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) box1 <= 1'b0;
    else       box1 <= in_box;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      de1   <= 1'b0;
      hs1   <= 1'b0;
      vs1   <= 1'b0;
      grad1 <= '0;
      bar1  <= '0;
      chk1  <= 1'b0;
    end else begin
      de1   <= dataEnable;
      hs1   <= hSync;
      vs1   <= vSync;
      grad1 <= hPos[9:2];
      bar1  <= bar_d;
      chk1  <= hPos[5] ^ vPos[5];
    end
  end

  always_comb begin
    rgb_d = 24'h000000;
    if (de1) begin
      case (pat)
        2'd0: rgb_d = {{8{~bar1[1]}}, {8{~bar1[2]}}, {8{~bar1[0]}}};
        2'd1: rgb_d = {grad1, grad1, grad1};
        2'd2: rgb_d = chk1 ? 24'hFFFFFF : 24'h000000;
`ifdef TEST_PATTERN_MOVING_BOX_EN
        2'd3: rgb_d = box1 ? 24'hFFFFFF : 24'h0000FF;
`endif
        default: rgb_d = 24'h000000;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dataEnableOut <= 1'b0;
      hSyncOut      <= 1'b0;
      vSyncOut      <= 1'b0;
      red           <= '0;
      green         <= '0;
      blue          <= '0;
    end else begin
      dataEnableOut <= de1;
      hSyncOut      <= hs1;
      vSyncOut      <= vs1;
      {red, green, blue} <= rgb_d;
    end
  end

endmodule

// File: tb/tb_video_test_pattern_gen.sv
// Bench for video_test_pattern_gen (default build, FRAMES_PER_PATTERN=2) using a compressed raster.
// Expected pixels are queued as inputs are driven and compared two clocks later.
module tb_video_test_pattern_gen;

  localparam int HA  = 1280;
  localparam int FPP = 2;

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [23:0] rgb;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        dataEnable = 1'b0, hSync = 1'b0, vSync = 1'b0;
  logic [11:0] hPos = '0;
  logic [10:0] vPos = '0;
  logic        autoAdvance = 1'b0, advance = 1'b0;
  logic        dataEnableOut, hSyncOut, vSyncOut;
  logic [7:0]  red, green, blue;
  logic [1:0]  patternIndex;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  int   m_pat = 0, m_fc = 0;
  bit   m_pend = 1'b0;

  video_test_pattern_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(720), .FRAMES_PER_PATTERN(FPP), .BOX_SIZE(64)
  ) dut (
    .clock(clock), .reset(reset), .dataEnable(dataEnable), .hSync(hSync), .vSync(vSync),
    .hPos(hPos), .vPos(vPos), .autoAdvance(autoAdvance), .advance(advance),
    .dataEnableOut(dataEnableOut), .hSyncOut(hSyncOut), .vSyncOut(vSyncOut),
    .red(red), .green(green), .blue(blue), .patternIndex(patternIndex)
  );

  always #5 clock = ~clock;

  function automatic logic [23:0] colour(int p, int h, int v);
    logic [23:0] bars [8];
    logic [7:0]  g;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    g = 8'((h % 1024) / 4);
    case (p)
      0: return bars[(h * 8) / HA];
      1: return {g, g, g};
      2: return ((((h / 32) % 2) ^ ((v / 32) % 2)) != 0) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  // One pixel clock: score the output due now, then drive and predict the next pixel.
  task automatic step(input logic de, input logic hs, input logic vs,
                      input int h, input int v, input logic adv);
    exp_t e, got;
    bit   fs;
    @(negedge clock);
    got = {dataEnableOut, hSyncOut, vSyncOut, red, green, blue};
    if (q.size() == 2) begin
      e = q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL pixel @%0t: got de=%b hs=%b vs=%b rgb=%06h, want de=%b hs=%b vs=%b rgb=%06h",
                 $time, got.de, got.hs, got.vs, got.rgb, e.de, e.hs, e.vs, e.rgb);
      end
    end
    n_cmp++;
    if (patternIndex !== 2'(m_pat)) begin
      n_bad++;
      $display("FAIL patternIndex @%0t: got %0d want %0d", $time, patternIndex, m_pat);
    end
    dataEnable = de; hSync = hs; vSync = vs;
    hPos = 12'(h); vPos = 11'(v); advance = adv;
    fs = de && (h == 0) && (v == 0);
    if (fs) begin
      if ((m_fc == FPP - 1 && autoAdvance) || m_pend) m_pat = (m_pat + 1) % 3;
      m_fc   = (m_fc == FPP - 1 || m_pend) ? 0 : m_fc + 1;
      m_pend = adv;
    end else if (adv) begin
      m_pend = 1'b1;
    end
    e.de = de; e.hs = hs; e.vs = vs;
    e.rgb = de ? colour(m_pat, h, v) : 24'h000000;
    q.push_back(e);
  endtask

  task automatic drive_frame(input int npix, input int nlines, input int adv_mid, input bit adv_fs);
    logic a;
    for (int y = 0; y < nlines; y++) begin
      for (int x = 0; x < npix; x++) begin
        a = (y == 0) && ((adv_mid >= 1 && x == 10) || (adv_mid >= 2 && x == 20) || (adv_fs && x == 0));
        step(1'b1, 1'b0, 1'b0, x, y, a);
      end
      for (int i = 0; i < 8; i++) step(1'b0, (i >= 2 && i < 6), 1'b0, npix + i, y, 1'b0);
    end
    for (int y2 = 0; y2 < 2; y2++)
      for (int i = 0; i < npix + 8; i++)
        step(1'b0, (i >= npix + 2 && i < npix + 6), (y2 == 0), i, nlines + y2, 1'b0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    dataEnable = 0; hSync = 0; vSync = 0; hPos = '0; vPos = '0; advance = 0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({dataEnableOut, hSyncOut, vSyncOut, red, green, blue, patternIndex} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got de=%b hs=%b vs=%b rgb=%02h%02h%02h pat=%0d, want all 0",
               dataEnableOut, hSyncOut, vSyncOut, red, green, blue, patternIndex);
    end
    q.delete();
    m_pat = 0; m_fc = 0; m_pend = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_colour_bars();
    autoAdvance = 1'b0;
    drive_frame(HA, 1, 0, 1'b0);
  endtask

  task automatic test_blanking();
    autoAdvance = 1'b0;
    drive_frame(128, 3, 0, 1'b0);
  endtask

  task automatic test_auto_advance();
    int seq [7];
    seq = '{0, 0, 1, 1, 2, 2, 0};
    apply_reset();
    autoAdvance = 1'b1;
    for (int f = 0; f < 7; f++) begin
      n_cmp++;
      if (patternIndex !== 2'(seq[f])) begin
        n_bad++;
        $display("FAIL auto_seq[%0d]: got %0d want %0d", f, patternIndex, seq[f]);
      end
      if (f < 6) drive_frame(128, 2, 0, 1'b0);
    end
    autoAdvance = 1'b0;
  endtask

  task automatic test_simultaneous_advance();
    int want [3];
    want = '{1, 2, 2};
    apply_reset();
    autoAdvance = 1'b1;
    drive_frame(64, 2, 2, 1'b0);
    for (int f = 0; f < 3; f++) begin
      drive_frame(64, 2, 0, (f == 0));
      n_cmp++;
      if (patternIndex !== 2'(want[f])) begin
        n_bad++;
        $display("FAIL simul_adv[%0d]: got %0d want %0d", f, patternIndex, want[f]);
      end
    end
    autoAdvance = 1'b0;
  endtask

  task automatic test_reset_mid();
    n_cmp++;
    if (m_pat != 2 || patternIndex !== 2'd2) begin
      n_bad++;
      $display("FAIL pre_reset_pattern: got %0d want 2", patternIndex);
    end
    for (int x = 1; x <= 40; x++) step(1'b1, 1'b0, 1'b0, x, 5, 1'b0);
    #2 reset = 1'b1;
    dataEnable = 1'b0;
    #1;
    n_cmp++;
    if ({dataEnableOut, red, green, blue, patternIndex} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got de=%b rgb=%02h%02h%02h pat=%0d, want 0",
               dataEnableOut, red, green, blue, patternIndex);
    end
    apply_reset();
    drive_frame(HA, 1, 0, 1'b0);
    n_cmp++;
    if (patternIndex !== 2'd0) begin
      n_bad++;
      $display("FAIL post_reset_pattern: got %0d want 0", patternIndex);
    end
  endtask

  initial begin
    test_reset();
    test_colour_bars();
    test_blanking();
    test_auto_advance();
    test_simultaneous_advance();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
